// File: rtl/fft_seq_ctrl.sv
// fft_seq_ctrl -- sequencer for a 16-point radix-2 in-place FFT datapath.
//
// After a start pulse the block issues 4 stages x 8 butterflies, one
// butterfly per cycle, as {stage, butterfly} index pairs for the read-address
// LUT.  A BF_LATENCY-deep pipeline delays each issued pair so a second LUT can
// produce the matching in-place write-back address.  Between stages the issue
// side pauses for BF_LATENCY cycles so that the next stage never reads a
// location the previous stage has not yet written back.
//
// Parameters:
//   BF_LATENCY    read-issue to write-back latency in cycles (1..7)
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   abort         (only with FFT_SEQ_CTRL_ABORT_EN) cancel the run, flush pipe
//   start         one-cycle request to run one FFT, honoured only in IDLE
//   stage         read-side stage index
//   butterfly     read-side butterfly index
//   rd_en         read issue valid
//   wr_stage      write-side stage index
//   wr_butterfly  write-side butterfly index
//   wr_en         write-back valid
//   busy          high from first issue through last write-back
//   done          one-cycle pulse after the final write-back
//
// Optional feature macro: FFT_SEQ_CTRL_ABORT_EN adds the abort input.

module fft_seq_ctrl #(
    parameter int unsigned BF_LATENCY = 2
) (
    input  logic       clk,
    input  logic       rst,
`ifdef FFT_SEQ_CTRL_ABORT_EN
    input  logic       abort,
`endif
    input  logic       start,
    output logic [1:0] stage,
    output logic [2:0] butterfly,
    output logic       rd_en,
    output logic [1:0] wr_stage,
    output logic [2:0] wr_butterfly,
    output logic       wr_en,
    output logic       busy,
    output logic       done
);

    if (BF_LATENCY < 1 || BF_LATENCY > 7) begin : g_bad_latency
        $error("fft_seq_ctrl: BF_LATENCY must be in 1..7");
    end

    localparam logic [2:0] DRAIN_LAST = 3'(BF_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] stage_q, stage_d;
    logic [2:0] bf_q, bf_d;
    logic [2:0] drain_q, drain_d;
    logic       flush;

    // {valid, stage, butterfly} per pipeline slot
    logic [5:0] pipe_q [BF_LATENCY];

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        bf_d    = bf_q;
        drain_d = drain_q;
        rd_en   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;

        unique case (state_q)
            IDLE: begin
                stage_d = '0;
                bf_d    = '0;
                drain_d = '0;
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                rd_en = 1'b1;
                busy  = 1'b1;
                if (bf_q == 3'd7) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end else begin
                    bf_d = bf_q + 3'd1;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (drain_q == DRAIN_LAST) begin
                    drain_d = '0;
                    bf_d    = '0;
                    // stage 3 in DRAIN means the last stage has been issued
                    if (stage_q == 2'd3) begin
                        state_d = DONE;
                        stage_d = '0;
                    end else begin
                        state_d = RUN;
                        stage_d = stage_q + 2'd1;
                    end
                end else begin
                    drain_d = drain_q + 3'd1;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        flush = rst;
`ifdef FFT_SEQ_CTRL_ABORT_EN
        flush = rst | abort;
`endif
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            state_q <= IDLE;
            stage_q <= '0;
            bf_q    <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            bf_q    <= bf_d;
            drain_q <= drain_d;
        end
    end

    // Indices are zeroed when not valid so the write side reads 0 whenever
    // wr_en is low, including across drain gaps.
    always_ff @(posedge clk) begin
        if (flush) begin
            for (int unsigned i = 0; i < BF_LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= rd_en ? {1'b1, stage_q, bf_q} : '0;
            for (int unsigned i = 1; i < BF_LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign stage        = stage_q;
    assign butterfly    = bf_q;
    assign wr_en        = pipe_q[BF_LATENCY-1][5];
    assign wr_stage     = pipe_q[BF_LATENCY-1][4:3];
    assign wr_butterfly = pipe_q[BF_LATENCY-1][2:0];

endmodule
